cdr_sync_ctrl: RTL and testbench

//  Sequencer for the CDR decision stage. Drives its run/reset line and symbol-period config (nb_P).

---
 rtl/cdr_sync_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_cdr_sync_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdr_sync_ctrl.sv
// CDR decision-stage sequencer: re-arms the decision block, hunts preamble and SFD,
// then forwards payload bits while a symbol-strobe watchdog guards the lock.
module cdr_sync_ctrl #(
    parameter int unsigned PRE_LEN = 16,
    parameter logic        PRE_BIT = 1'b0,
    parameter logic [7:0]  SFD     = 8'hA7,
    parameter int unsigned SFD_TMO = 32,
    parameter int unsigned REARM   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [5:0] i_nb_P_cfg,
    input  logic       i_data,
    input  logic       i_dflag,
    output logic       o_dec_run,
    output logic [5:0] o_nb_P,
    output logic       o_lock,
    output logic       o_sfd_det,
    output logic       o_bit,
    output logic       o_bit_vld,
    output logic [1:0] o_err,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REARM    = 3'd1,
        ST_ACQ      = 3'd2,
        ST_SFD_SRCH = 3'd3,
        ST_LOCK     = 3'd4
    } state_e;

    localparam logic [7:0] PRE_LEN_C  = 8'(PRE_LEN);
    localparam logic [7:0] SFD_TMO_C  = 8'(SFD_TMO);
    localparam logic [7:0] REARM_LAST = 8'(REARM - 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SFD_TMO = 2'd1;
    localparam logic [1:0] ERR_WDOG    = 2'd2;
    localparam logic [1:0] ERR_CFG     = 2'd3;

    state_e     state_q, state_d;
    logic [7:0] rearm_cnt_q, rearm_cnt_d;
    logic [7:0] pre_cnt_q, pre_cnt_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] sym_cnt_q, sym_cnt_d;
    logic [7:0] gap_q, gap_d;
    logic [5:0] nb_p_q, nb_p_d;
    logic [1:0] err_q, err_d;
    logic       dec_run_q, dec_run_d;
    logic       lock_q, lock_d;
    logic       sfd_det_q, sfd_det_d;
    logic       data_bit_q, data_bit_d;
    logic       bit_vld_q, bit_vld_d;

    logic       active;
    logic       wd_hit;
    logic [8:0] wd_limit;
    logic [7:0] sr_shift;
    logic [7:0] sym_inc;
    logic [7:0] pre_inc;

    always_comb begin
        // NOTE: every _d defaults to its _q (or a pulse default) first so no path leaves a latch.
        state_d     = state_q;
        rearm_cnt_d = rearm_cnt_q;
        pre_cnt_d   = pre_cnt_q;
        sr_d        = sr_q;
        sym_cnt_d   = sym_cnt_q;
        nb_p_d      = nb_p_q;
        err_d       = err_q;
        data_bit_d  = data_bit_q;
        sfd_det_d   = 1'b0;
        bit_vld_d   = 1'b0;

        active   = (state_q == ST_ACQ) || (state_q == ST_SFD_SRCH) || (state_q == ST_LOCK);
        wd_limit = {2'b00, nb_p_q, 1'b0} + 9'd2;
        wd_hit   = active && ({1'b0, gap_q} == wd_limit);
        sr_shift = {i_data, sr_q[7:1]};
        sym_inc  = sym_cnt_q + 8'd1;
        pre_inc  = (pre_cnt_q == 8'hFF) ? pre_cnt_q : pre_cnt_q + 8'd1;

        if (i_abort) begin
            state_d = ST_IDLE;
        end else if (wd_hit) begin
            state_d     = ST_REARM;
            rearm_cnt_d = 8'd0;
            err_d       = ERR_WDOG;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_nb_P_cfg < 6'd3) begin
                            err_d = ERR_CFG;
                        end else begin
                            nb_p_d      = i_nb_P_cfg;
                            err_d       = ERR_NONE;
                            state_d     = ST_REARM;
                            rearm_cnt_d = 8'd0;
                        end
                    end
                end
                ST_REARM: begin
                    if (rearm_cnt_q == REARM_LAST) begin
                        state_d   = ST_ACQ;
                        pre_cnt_d = 8'd0;
                    end else begin
                        rearm_cnt_d = rearm_cnt_q + 8'd1;
                    end
                end
                ST_ACQ: begin
                    if (i_dflag) begin
                        if (i_data == PRE_BIT) begin
                            pre_cnt_d = pre_inc;
                            if (pre_inc == PRE_LEN_C) begin
                                state_d   = ST_SFD_SRCH;
                                sr_d      = 8'd0;
                                sym_cnt_d = 8'd0;
                            end
                        end else begin
                            pre_cnt_d = 8'd0;
                        end
                    end
                end
                ST_SFD_SRCH: begin
                    if (i_dflag) begin
                        sr_d      = sr_shift;
                        sym_cnt_d = sym_inc;
                        if (sr_shift == SFD) begin
                            state_d   = ST_LOCK;
                            sfd_det_d = 1'b1;
                        end else if (sym_inc == SFD_TMO_C) begin
                            state_d     = ST_REARM;
                            rearm_cnt_d = 8'd0;
                            err_d       = ERR_SFD_TMO;
                        end
                    end
                end
                ST_LOCK: begin
                    if (i_dflag) begin
                        data_bit_d = i_data;
                        bit_vld_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Gap restarts on every strobe and on any state change, so each watched state starts fresh.
        if (i_dflag || (state_d != state_q)) begin
            gap_d = 8'd0;
        end else if (gap_q != 8'hFF) begin
            gap_d = gap_q + 8'd1;
        end else begin
            gap_d = gap_q;
        end

        dec_run_d = (state_d == ST_ACQ) || (state_d == ST_SFD_SRCH) || (state_d == ST_LOCK);
        lock_d    = (state_d == ST_LOCK);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            rearm_cnt_q <= 8'd0;
            pre_cnt_q   <= 8'd0;
            sr_q        <= 8'd0;
            sym_cnt_q   <= 8'd0;
            gap_q       <= 8'd0;
            nb_p_q      <= 6'd0;
            err_q       <= ERR_NONE;
            dec_run_q   <= 1'b0;
            lock_q      <= 1'b0;
            sfd_det_q   <= 1'b0;
            data_bit_q  <= 1'b0;
            bit_vld_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
            state_q     <= state_d;
            rearm_cnt_q <= rearm_cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            sr_q        <= sr_d;
            sym_cnt_q   <= sym_cnt_d;
            gap_q       <= gap_d;
            nb_p_q      <= nb_p_d;
            err_q       <= err_d;
            dec_run_q   <= dec_run_d;
            lock_q      <= lock_d;
            sfd_det_q   <= sfd_det_d;
            data_bit_q  <= data_bit_d;
            bit_vld_q   <= bit_vld_d;
        end
    end

    assign o_dec_run = dec_run_q;
    assign o_nb_P    = nb_p_q;
    assign o_lock    = lock_q;
    assign o_sfd_det = sfd_det_q;
    assign o_bit     = data_bit_q;
    assign o_bit_vld = bit_vld_q;
    assign o_err     = err_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_cdr_sync_ctrl.sv
// Directed bench for cdr_sync_ctrl: a vector table for start/abort/cfg handling in IDLE,
// then hand-written sequences for acquisition, SFD timeout, watchdog and reset.
module tb_cdr_sync_ctrl;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REARM = 3'd1;
    localparam logic [2:0] S_ACQ   = 3'd2;
    localparam logic [2:0] S_SFD   = 3'd3;
    localparam logic [2:0] S_LOCK  = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] cfg = 6'd0;
    logic       data = 1'b0;
    logic       dflag = 1'b0;

    logic       dec_run;
    logic [5:0] nb_p;
    logic       lock;
    logic       sfd_det;
    logic       pbit;
    logic       bit_vld;
    logic [1:0] err;
    logic [2:0] state;

    int n_total = 0;
    int n_pass  = 0;

    cdr_sync_ctrl dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_abort    (abort),
        .i_nb_P_cfg (cfg),
        .i_data     (data),
        .i_dflag    (dflag),
        .o_dec_run  (dec_run),
        .o_nb_P     (nb_p),
        .o_lock     (lock),
        .o_sfd_det  (sfd_det),
        .o_bit      (pbit),
        .o_bit_vld  (bit_vld),
        .o_err      (err),
        .o_state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       abort;
        logic [5:0] cfg;
        logic [2:0] exp_state;
        logic [1:0] exp_err;
        logic [5:0] exp_nbp;
        logic       exp_run;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic flag(input logic b);
        data  = b;
        dflag = 1'b1;
        tick();
        dflag = 1'b0;
    endtask

    task automatic sym(input logic b, input int period);
        flag(b);
        idle(period - 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_dec_run"}, 32'(dec_run), 32'd0);
        check({tag, "_nb_p"},    32'(nb_p),    32'd0);
        check({tag, "_lock"},    32'(lock),    32'd0);
        check({tag, "_sfd_det"}, 32'(sfd_det), 32'd0);
        check({tag, "_bit"},     32'(pbit),    32'd0);
        check({tag, "_bit_vld"}, 32'(bit_vld), 32'd0);
        check({tag, "_err"},     32'(err),     32'd0);
        check({tag, "_state"},   32'(state),   32'(S_IDLE));
    endtask

    initial begin
        logic [7:0] sfd_v;
        logic [3:0] pay;
        sfd_v = 8'hA7;
        pay   = 4'b1101;

        //             start abort cfg    state    err   nbP    run
        vecs[0] = '{1'b1, 1'b0, 6'd2,  S_IDLE,  2'd3, 6'd0,  1'b0};
        vecs[1] = '{1'b1, 1'b0, 6'd0,  S_IDLE,  2'd3, 6'd0,  1'b0};
        vecs[2] = '{1'b0, 1'b0, 6'd9,  S_IDLE,  2'd3, 6'd0,  1'b0};
        vecs[3] = '{1'b1, 1'b0, 6'd8,  S_REARM, 2'd0, 6'd8,  1'b0};
        vecs[4] = '{1'b1, 1'b0, 6'd20, S_REARM, 2'd0, 6'd8,  1'b0};
        vecs[5] = '{1'b0, 1'b1, 6'd20, S_IDLE,  2'd0, 6'd8,  1'b0};
        vecs[6] = '{1'b1, 1'b1, 6'd5,  S_IDLE,  2'd0, 6'd8,  1'b0};
        vecs[7] = '{1'b1, 1'b0, 6'd3,  S_REARM, 2'd0, 6'd3,  1'b0};
        vecs[8] = '{1'b0, 1'b1, 6'd3,  S_IDLE,  2'd0, 6'd3,  1'b0};

        #2 rst = 1'b1;
        tick();
        check_reset("reset");
        @(negedge clk) rst = 1'b0;
        tick();

        // IDLE start / abort / cfg handling
        for (int i = 0; i < 9; i++) begin
            start = vecs[i].start;
            abort = vecs[i].abort;
            cfg   = vecs[i].cfg;
            tick();
            start = 1'b0;
            abort = 1'b0;
            check($sformatf("vec%0d_state", i), 32'(state),   32'(vecs[i].exp_state));
            check($sformatf("vec%0d_err", i),   32'(err),     32'(vecs[i].exp_err));
            check($sformatf("vec%0d_nbp", i),   32'(nb_p),    32'(vecs[i].exp_nbp));
            check($sformatf("vec%0d_run", i),   32'(dec_run), 32'(vecs[i].exp_run));
        end

        // T1: full acquisition at nb_P=10, flag period 10
        cfg   = 6'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg   = 6'd40;
        check("t1_rearm_state", 32'(state), 32'(S_REARM));
        check("t1_nbp", 32'(nb_p), 32'd10);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t1_rearm_run%0d", i), 32'(dec_run), 32'd0);
        end
        tick();
        check("t1_run_rise", 32'(dec_run), 32'd1);
        check("t1_acq_state", 32'(state), 32'(S_ACQ));
        for (int i = 0; i < 15; i++) sym(1'b0, 10);
        check("t1_acq_after15", 32'(state), 32'(S_ACQ));
        flag(1'b0);
        check("t1_sfd_entry16", 32'(state), 32'(S_SFD));
        idle(9);
        for (int i = 0; i < 7; i++) sym(sfd_v[i], 10);
        check("t1_sfd_before8", 32'(state), 32'(S_SFD));
        check("t1_sfd_det_low", 32'(sfd_det), 32'd0);
        flag(sfd_v[7]);
        check("t1_sfd_det", 32'(sfd_det), 32'd1);
        check("t1_lock", 32'(lock), 32'd1);
        check("t1_lock_state", 32'(state), 32'(S_LOCK));
        check("t1_no_vld_on_det", 32'(bit_vld), 32'd0);
        tick();
        check("t1_sfd_det_pulse", 32'(sfd_det), 32'd0);
        check("t1_lock_held", 32'(lock), 32'd1);
        check("t1_nbp_unchanged", 32'(nb_p), 32'd10);
        idle(8);

        // Payload with one-cycle latency
        for (int i = 0; i < 4; i++) begin
            flag(pay[i]);
            check($sformatf("pay%0d_vld", i), 32'(bit_vld), 32'd1);
            check($sformatf("pay%0d_bit", i), 32'(pbit), 32'(pay[i]));
            tick();
            check($sformatf("pay%0d_vld_pulse", i), 32'(bit_vld), 32'd0);
            idle(8);
        end

        // T4: watchdog, nine quiet cycles already elapsed; limit 2*10+2 = 22
        idle(13);
        check("t4_lock_at_gap22", 32'(lock), 32'd1);
        tick();
        check("t4_lock_drop", 32'(lock), 32'd0);
        check("t4_err", 32'(err), 32'd2);
        check("t4_state", 32'(state), 32'(S_REARM));
        check("t4_run_low", 32'(dec_run), 32'd0);
        idle(3);
        check("t4_still_rearm", 32'(state), 32'(S_REARM));
        tick();
        check("t4_back_acq", 32'(state), 32'(S_ACQ));
        check("t4_run_high", 32'(dec_run), 32'd1);

        // T2: a 1 at bit 15 restarts the preamble count
        for (int i = 0; i < 30; i++) sym((i == 14), 5);
        check("t2_acq_after30", 32'(state), 32'(S_ACQ));
        flag(1'b0);
        check("t2_sfd_entry31", 32'(state), 32'(S_SFD));
        check("t2_err_sticky", 32'(err), 32'd2);
        idle(4);

        // T3: SFD timeout after 32 non-matching symbols
        for (int i = 0; i < 31; i++) sym(1'b0, 5);
        check("t3_sfd_after31", 32'(state), 32'(S_SFD));
        flag(1'b0);
        check("t3_rearm", 32'(state), 32'(S_REARM));
        check("t3_err", 32'(err), 32'd1);
        check("t3_run_low", 32'(dec_run), 32'd0);
        idle(3);
        check("t3_still_rearm", 32'(dec_run), 32'd0);
        tick();
        check("t3_back_acq", 32'(state), 32'(S_ACQ));
        check("t3_run_high", 32'(dec_run), 32'd1);

        // T6: relock, then asynchronous reset mid-LOCK
        for (int i = 0; i < 16; i++) sym(1'b0, 5);
        for (int i = 0; i < 8; i++) sym(sfd_v[i], 5);
        check("t6_relock", 32'(lock), 32'd1);
        flag(1'b1);
        check("t6_pay_vld", 32'(bit_vld), 32'd1);
        check("t6_pay_bit", 32'(pbit), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset("t6_async");
        tick();
        tick();
        rst = 1'b0;
        idle(3);
        check("t6_idle_held", 32'(state), 32'(S_IDLE));
        check("t6_run_low", 32'(dec_run), 32'd0);
        abort = 1'b1;
        start = 1'b1;
        cfg   = 6'd12;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("t6_abort_start_state", 32'(state), 32'(S_IDLE));
        check("t6_abort_start_nbp", 32'(nb_p), 32'd0);
        check("t6_abort_start_err", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
